// File: rtl/e1of2_sync_tx_pkg.sv
// Shared widths, FSM state type and dual-rail (e1of2) encoding helpers for the
// synchronous-to-asynchronous NoC packet transmitter.
package e1of2_sync_tx_pkg;

  localparam int FLIT_W   = 9;
  localparam int ADDR_W   = 4;
  localparam int HDR_MARK = FLIT_W - 1;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    flit_t d1;
    flit_t d0;
  } rails_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WAIT_LO,
    S_WAIT_HI,
    S_FETCH
  } state_t;

  // A 1 bit raises its true rail, a 0 bit raises its false rail.
  function automatic rails_t dr_encode(input flit_t f);
    rails_t r;
    r.d1 = f;
    r.d0 = ~f;
    return r;
  endfunction

  function automatic rails_t dr_null();
    rails_t r;
    r = '0;
    return r;
  endfunction

  function automatic flit_t make_header(input addr_t dest);
    flit_t h;
    h               = '0;
    h[HDR_MARK]     = 1'b1;
    h[ADDR_W-1:0]   = dest;
    return h;
  endfunction

endpackage

// File: rtl/e1of2_sync_tx_if.sv
// Core-side packet bus plus the dual-rail output channel of the transmitter.
interface e1of2_sync_tx_if;
  import e1of2_sync_tx_pkg::*;

  logic  pkt_valid;
  logic  pkt_ready;
  flit_t pkt_data;
  logic  pkt_last;
  addr_t pkt_dest;
  flit_t Out_d0;
  flit_t Out_d1;
  logic  Out_e;

  modport master (
    output pkt_valid, pkt_data, pkt_last, pkt_dest, Out_e,
    input  pkt_ready, Out_d0, Out_d1
  );

  modport slave (
    input  pkt_valid, pkt_data, pkt_last, pkt_dest, Out_e,
    output pkt_ready, Out_d0, Out_d1
  );

endinterface

// File: rtl/e1of2_sync_tx_e_sync.sv
// Multi-flop synchronizer for the asynchronous receiver enable; all stages clear on reset.
module e_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_reg [STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (!rst_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= d;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (!rst_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/e1of2_sync_tx.sv
// Packet injector: accepts flits from the clocked core, prepends a routing header and
// emits each flit as a 4-phase e1of2 token on flop-driven dual rails.
module e1of2_sync_tx
  import e1of2_sync_tx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic           CLK,
  input  logic           _RESET,
  e1of2_sync_tx_if.slave bus,
  output logic           stall_err,
  output logic [15:0]    flit_cnt
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  state_t               state_reg;
  rails_t               rails_reg;
  logic                 pkt_ready_reg;
  addr_t                dest_reg;
  flit_t                hold_reg;
  logic                 last_reg;
  logic                 hdr_phase_reg;
  logic [15:0]          flit_cnt_reg;
  logic [TIMER_W-1:0]   timer_reg;
  logic                 stall_reg;

  logic e_s;
  logic accept;
  logic advance;
  logic waiting;

  e_sync #(.STAGES(SYNC_STAGES)) u_e_sync (
    .clk   (CLK),
    .rst_n (_RESET),
    .d     (bus.Out_e),
    .q     (e_s)
  );

  assign accept = bus.pkt_valid && pkt_ready_reg;

  // The timeout counts any cycle spent waiting on the receiver enable, including the
  // wait for the first enable before a header, so a dead receiver is always flagged.
  always_comb begin
    advance = 1'b0;
    waiting = 1'b0;
    case (state_reg)
      S_IDLE, S_FETCH:        advance = accept;
      S_HDR, S_DATA:          begin advance = e_s;  waiting = 1'b1; end
      S_WAIT_LO:              begin advance = !e_s; waiting = 1'b1; end
      S_WAIT_HI:              begin advance = e_s;  waiting = 1'b1; end
      default:                advance = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      state_reg     <= S_IDLE;
      rails_reg     <= dr_null();
      pkt_ready_reg <= 1'b0;
      dest_reg      <= '0;
      hold_reg      <= '0;
      last_reg      <= 1'b0;
      hdr_phase_reg <= 1'b0;
      flit_cnt_reg  <= '0;
      timer_reg     <= '0;
      stall_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            dest_reg      <= bus.pkt_dest;
            hold_reg      <= bus.pkt_data;
            last_reg      <= bus.pkt_last;
            pkt_ready_reg <= 1'b0;
            state_reg     <= S_HDR;
          end else begin
            pkt_ready_reg <= 1'b1;
          end
        end
        S_HDR: begin
          if (e_s) begin
            rails_reg     <= dr_encode(make_header(dest_reg));
            hdr_phase_reg <= 1'b1;
            state_reg     <= S_WAIT_LO;
          end
        end
        S_DATA: begin
          if (e_s) begin
            rails_reg     <= dr_encode(hold_reg);
            hdr_phase_reg <= 1'b0;
            state_reg     <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!e_s) begin
            rails_reg    <= dr_null();
            flit_cnt_reg <= flit_cnt_reg + 16'd1;
            state_reg    <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (e_s) begin
            if (hdr_phase_reg) begin
              state_reg <= S_DATA;
            end else if (last_reg) begin
              pkt_ready_reg <= 1'b1;
              state_reg     <= S_IDLE;
            end else begin
              pkt_ready_reg <= 1'b1;
              state_reg     <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (accept) begin
            hold_reg      <= bus.pkt_data;
            last_reg      <= bus.pkt_last;
            pkt_ready_reg <= 1'b0;
            state_reg     <= S_DATA;
          end else begin
            pkt_ready_reg <= 1'b1;
          end
        end
        default: begin
          rails_reg     <= dr_null();
          pkt_ready_reg <= 1'b0;
          state_reg     <= S_IDLE;
        end
      endcase

      // Saturating stall timer; restarts whenever the handshake makes progress.
      if (advance || !waiting) begin
        timer_reg <= '0;
      end else if (timer_reg != TIMER_W'(TIMEOUT)) begin
        timer_reg <= timer_reg + 1'b1;
      end

      if (timer_reg == TIMER_W'(TIMEOUT)) begin
        stall_reg <= 1'b1;
      end
    end
  end

  assign bus.pkt_ready = pkt_ready_reg;
  assign bus.Out_d0    = rails_reg.d0;
  assign bus.Out_d1    = rails_reg.d1;
  assign stall_err     = stall_reg;
  assign flit_cnt      = flit_cnt_reg;

endmodule

// File: tb/tb_e1of2_sync_tx.sv
// Scoreboard bench for the e1of2 packet transmitter with a 4-phase receiver model.
module tb_e1of2_sync_tx;
  import e1of2_sync_tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_err;
  logic [15:0] flit_cnt;

  e1of2_sync_tx_if bus();

  e1of2_sync_tx #(.SYNC_STAGES(2), .TIMEOUT(1023)) dut (
    .CLK       (clk),
    ._RESET    (rst_n),
    .bus       (bus),
    .stall_err (stall_err),
    .flit_cnt  (flit_cnt)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  flit_t exp_q[$];
  bit    mon_en   = 1'b0;
  bit    rx_auto  = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit rails_null();
    return (bus.Out_d0 | bus.Out_d1) == '0;
  endfunction

  // Receiver: lowers enable once a token is seen, raises it again on null.
  initial begin
    bus.Out_e = 1'b1;
    forever begin
      @(negedge clk);
      if (!rx_auto)          bus.Out_e = 1'b0;
      else if (rails_null()) bus.Out_e = 1'b1;
      else                   bus.Out_e = 1'b0;
    end
  end

  // Monitor: protocol checks every cycle, scoreboard pop on each null-to-valid edge.
  initial begin
    flit_t d0, d1, pd1, e;
    bit    is_null, is_valid, pvalid;
    pvalid = 1'b0;
    pd1    = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        pvalid = 1'b0;
        continue;
      end
      d0       = bus.Out_d0;
      d1       = bus.Out_d1;
      is_null  = (d0 | d1) == '0;
      is_valid = ((d0 | d1) == '1) && ((d0 & d1) == '0);
      n_checks++;
      if (!is_null && !is_valid) begin
        n_fail++;
        $display("FAIL rail_code: got d1=%0h d0=%0h expected a null or complete code", d1, d0);
      end
      n_checks++;
      if (is_valid && pvalid && d1 != pd1) begin
        n_fail++;
        $display("FAIL valid_to_valid: got d1=%0h after d1=%0h expected a null between", d1, pd1);
      end
      if (is_valid && !pvalid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_token: got d1=%0h d0=%0h expected no token", d1, d0);
        end else begin
          e = exp_q.pop_front();
          if (d1 != e || d0 != ~e) begin
            n_fail++;
            $display("FAIL token: got d1=%0h d0=%0h expected d1=%0h d0=%0h", d1, d0, e, ~e);
          end else begin
            $display("token d1=%0h d0=%0h ok", d1, d0);
          end
        end
      end
      pvalid = is_valid;
      pd1    = d1;
    end
  end

  // Waits for pkt_ready, optionally holds pkt_valid low for gap cycles, then offers one flit.
  task automatic send_flit(input flit_t data, input bit last, input addr_t dest, input int gap);
    int cyc;
    cyc = 0;
    while (!bus.pkt_ready && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.pkt_ready) begin
      chk("ready_timeout", 32'(bus.pkt_ready), 32'd1);
      return;
    end
    for (int i = 0; i < gap; i++) begin
      chk("gap_rails_null", 32'(rails_null()), 32'd1);
      chk("gap_ready", 32'(bus.pkt_ready), 32'd1);
      @(negedge clk);
    end
    exp_q.push_back(data);
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = data;
    bus.pkt_last  = last;
    bus.pkt_dest  = dest;
    @(posedge clk);
    #1;
    bus.pkt_valid = 1'b0;
    $display("sent flit %0h last=%0d dest=%0h", data, last, dest);
    @(negedge clk);
  endtask

  task automatic wait_done(input string name, input logic [15:0] exp_cnt);
    int cyc;
    cyc = 0;
    while (!(exp_q.size() == 0 && bus.pkt_ready) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_done"}, 32'(exp_q.size() == 0 && bus.pkt_ready), 32'd1);
    chk({name, "_flit_cnt"}, 32'(flit_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  seen_rails;
    rst_n         = 1'b0;
    bus.pkt_valid = 1'b0;
    bus.pkt_data  = '0;
    bus.pkt_last  = 1'b0;
    bus.pkt_dest  = '0;
    repeat (3) @(negedge clk);

    chk("rst_ready", 32'(bus.pkt_ready), 32'd0);
    chk("rst_d0", 32'(bus.Out_d0), 32'd0);
    chk("rst_d1", 32'(bus.Out_d1), 32'd0);
    chk("rst_cnt", 32'(flit_cnt), 32'd0);
    chk("rst_stall", 32'(stall_err), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single-flit packet: header 1_0000_0101, then payload 0A5.
    exp_q.push_back(9'h105);
    send_flit(9'h0A5, 1'b1, 4'h5, 0);
    wait_done("pkt1", 16'd2);

    // Three flits, gap before the second, destination changes mid-packet.
    exp_q.push_back(9'h10A);
    send_flit(9'h001, 1'b0, 4'hA, 0);
    send_flit(9'h1FF, 1'b0, 4'h3, 5);
    send_flit(9'h0C3, 1'b1, 4'h3, 0);
    wait_done("pkt3", 16'd6);
    chk("no_stall_yet", 32'(stall_err), 32'd0);

    // Reset while a token is on the rails.
    exp_q.push_back(9'h10F);
    send_flit(9'h155, 1'b1, 4'hF, 0);
    cyc = 0;
    while (rails_null() && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rails_valid_before_reset", 32'(rails_null()), 32'd0);
    mon_en  = 1'b0;
    rx_auto = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_d0", 32'(bus.Out_d0), 32'd0);
    chk("midrst_d1", 32'(bus.Out_d1), 32'd0);
    chk("midrst_ready", 32'(bus.pkt_ready), 32'd0);
    chk("midrst_cnt", 32'(flit_cnt), 32'd0);
    chk("midrst_stall", 32'(stall_err), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);

    // Receiver enable held low: nothing emitted, stall flag after the timeout.
    rst_n  = 1'b1;
    mon_en = 1'b1;
    exp_q.push_back(9'h102);
    send_flit(9'h07E, 1'b1, 4'h2, 0);
    seen_rails = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (!rails_null()) seen_rails = 1'b1;
      if (i == 1000) chk("stall_early", 32'(stall_err), 32'd0);
      @(negedge clk);
    end
    chk("stall_no_rails", 32'(seen_rails), 32'd0);
    chk("stall_set", 32'(stall_err), 32'd1);
    rx_auto = 1'b1;
    wait_done("stall_pkt", 16'd2);
    chk("stall_sticky", 32'(stall_err), 32'd1);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
